// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the SRAM arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_AUX = 1'b1;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    // On a tie the port that was not served last wins.
    if (req0 && req1)
      grant = ~rr_last;
    else
      grant = req0 ? P_CPU : P_AUX;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and fixed-window sequencer for the shared SRAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_drive
);

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       cur_we;
  logic       cur_port;
  logic       rr_last;
  logic       grant;
  logic       valid;
  logic       sel_we;

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  assign sel_we = grant ? we1 : we0;

  rr_arb2 u_rr_arb2 (
    .req0    (req0),
    .req1    (req1),
    .rr_last (rr_last),
    .grant   (grant),
    .valid   (valid)
  );

  // Strobes are registered so an async reset releases them without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cur_we       <= 1'b0;
      cur_port     <= P_CPU;
      rr_last      <= P_AUX;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= '0;
      Mem_OE       <= 1'b1;
      Mem_WE       <= 1'b1;
      Mem_drive    <= 1'b0;
      Mem_ADDR     <= '0;
      Data_to_SRAM <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            cur_port     <= grant;
            cur_we       <= sel_we;
            Mem_ADDR     <= grant ? addr1 : addr0;
            Data_to_SRAM <= grant ? wdata1 : wdata0;
            Mem_OE       <= sel_we;
            Mem_WE       <= ~sel_we;
            Mem_drive    <= sel_we;
            cnt          <= CNT_INIT;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!cur_we)
              rdata <= Data_from_SRAM;
            Mem_OE    <= 1'b1;
            Mem_WE    <= 1'b1;
            Mem_drive <= 1'b0;
            ack0      <= (cur_port == P_CPU);
            ack1      <= (cur_port == P_AUX);
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          rr_last <= cur_port;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a small SRAM model
module tb_mem_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        req0, we0, req1, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_drive;
  logic [19:0] Mem_ADDR;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;

  logic        b_req0, b_we0, b_req1, b_we1;
  logic [19:0] b_addr0, b_addr1;
  logic [15:0] b_wdata0, b_wdata1;
  logic        b_ack0, b_ack1;
  logic [15:0] b_rdata;
  logic        b_Mem_CE, b_Mem_UB, b_Mem_LB, b_Mem_OE, b_Mem_WE, b_Mem_drive;
  logic [19:0] b_Mem_ADDR;
  logic [15:0] b_Data_to_SRAM, b_Data_from_SRAM;

  logic [15:0] mem [0:255];

  int n_asserts = 0;
  int n_fails   = 0;

  mem_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Mem_drive(Mem_drive)
  );

  mem_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1),
    .rdata(b_rdata),
    .Mem_CE(b_Mem_CE), .Mem_UB(b_Mem_UB), .Mem_LB(b_Mem_LB), .Mem_OE(b_Mem_OE), .Mem_WE(b_Mem_WE),
    .Mem_ADDR(b_Mem_ADDR), .Data_to_SRAM(b_Data_to_SRAM), .Data_from_SRAM(b_Data_from_SRAM),
    .Mem_drive(b_Mem_drive)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: preloaded during reset, written on any edge that sees WE low.
  always @(posedge Clk) begin
    if (!Reset_n)
      mem[8'h10] <= 16'hBEEF;
    else if (!Mem_WE)
      mem[Mem_ADDR[7:0]] <= Data_to_SRAM;
  end
  assign Data_from_SRAM   = mem[Mem_ADDR[7:0]];
  assign b_Data_from_SRAM = b_Mem_OE ? 16'h0000 : 16'hCAFE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      check("acks_exclusive", 32'(ack0 & ack1), 0);
      check("oe_we_exclusive", 32'(!Mem_OE && !Mem_WE), 0);
    end
  end

  initial begin
    Reset_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
    repeat (2) @(negedge Clk);

    check("rst_oe", 32'(Mem_OE), 1);
    check("rst_we", 32'(Mem_WE), 1);
    check("rst_drive", 32'(Mem_drive), 0);
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_addr", 32'(Mem_ADDR), 0);
    check("rst_wdata", 32'(Data_to_SRAM), 0);
    check("tied_strobes", 32'({Mem_CE, Mem_UB, Mem_LB}), 0);
    Reset_n = 1'b1;

    // Single read by port 0
    req0 = 1; we0 = 0; addr0 = 20'h00010;
    step();
    check("rd_oe1", 32'(Mem_OE), 0);
    check("rd_we1", 32'(Mem_WE), 1);
    check("rd_addr", 32'(Mem_ADDR), 32'h10);
    check("rd_ack_early", 32'(ack0), 0);
    step();
    check("rd_oe2", 32'(Mem_OE), 0);
    check("rd_drive", 32'(Mem_drive), 0);
    step();
    check("rd_oe_done", 32'(Mem_OE), 1);
    check("rd_ack0", 32'(ack0), 1);
    check("rd_ack1", 32'(ack1), 0);
    check("rd_rdata", 32'(rdata), 32'hBEEF);
    req0 = 0;
    step();
    check("rd_ack0_gone", 32'(ack0), 0);

    // Single write by port 1, inputs disturbed after grant
    req1 = 1; we1 = 1; addr1 = 20'h00020; wdata1 = 16'h1234;
    step();
    check("wr_we1", 32'(Mem_WE), 0);
    check("wr_oe1", 32'(Mem_OE), 1);
    check("wr_drive1", 32'(Mem_drive), 1);
    check("wr_addr", 32'(Mem_ADDR), 32'h20);
    check("wr_data", 32'(Data_to_SRAM), 32'h1234);
    addr1 = 20'h00021; wdata1 = 16'hFFFF;
    step();
    check("wr_we2", 32'(Mem_WE), 0);
    check("wr_addr_held", 32'(Mem_ADDR), 32'h20);
    check("wr_data_held", 32'(Data_to_SRAM), 32'h1234);
    step();
    check("wr_ack1", 32'(ack1), 1);
    check("wr_ack0", 32'(ack0), 0);
    check("wr_strobes_off", 32'({Mem_WE, Mem_drive}), 32'b10);
    check("wr_mem", 32'(mem[8'h20]), 32'h1234);
    check("wr_rdata_kept", 32'(rdata), 32'hBEEF);
    req1 = 0;
    step();
    check("wr_ack1_gone", 32'(ack1), 0);

    // Contention: both read continuously, expect 0,1,0,1
    req0 = 1; we0 = 0; addr0 = 20'h00010;
    req1 = 1; we1 = 0; addr1 = 20'h00020;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_addr", 32'(Mem_ADDR), (i % 2 == 0) ? 32'h10 : 32'h20);
      step();
      step();
      check("rr_ack0", 32'(ack0), (i % 2 == 0) ? 1 : 0);
      check("rr_ack1", 32'(ack1), (i % 2 == 0) ? 0 : 1);
      check("rr_rdata", 32'(rdata), (i % 2 == 0) ? 32'hBEEF : 32'h1234);
      if (i == 3) begin
        req0 = 0;
        req1 = 0;
      end
      step();
      check("rr_idle", 32'({ack0, ack1, Mem_OE, Mem_WE}), 32'b0011);
    end

    // Write then read the same word: turnaround cycle in between
    req0 = 1; we0 = 1; addr0 = 20'h00003; wdata0 = 16'h5555;
    step();
    check("ta_we", 32'(Mem_WE), 0);
    step();
    step();
    check("ta_wr_ack", 32'(ack0), 1);
    we0 = 0;
    step();
    check("ta_gap", 32'({Mem_OE, Mem_WE, Mem_drive}), 32'b110);
    step();
    check("ta_rd_oe", 32'({Mem_OE, Mem_drive}), 32'b00);
    step();
    step();
    check("ta_rd_ack", 32'(ack0), 1);
    check("ta_rdata", 32'(rdata), 32'h5555);
    req0 = 0;
    step();

    // Async reset during second ACCESS cycle of a write
    req1 = 1; we1 = 1; addr1 = 20'h00030; wdata1 = 16'hAAAA;
    step();
    step();
    check("ar_we_low", 32'(Mem_WE), 0);
    #1 Reset_n = 1'b0;
    #1;
    check("ar_we_async", 32'(Mem_WE), 1);
    check("ar_drive_async", 32'(Mem_drive), 0);
    check("ar_addr_async", 32'(Mem_ADDR), 0);
    req1 = 0;
    step();
    check("ar_no_ack", 32'({ack0, ack1}), 0);
    Reset_n = 1'b1;
    req0 = 1; we0 = 0; addr0 = 20'h00010;
    req1 = 1; we1 = 0; addr1 = 20'h00020;
    step();
    check("ar_tie_addr", 32'(Mem_ADDR), 32'h10);
    step();
    step();
    check("ar_tie_ack0", 32'(ack0), 1);
    check("ar_tie_ack1", 32'(ack1), 0);
    req0 = 0; req1 = 0;
    step();

    // ACC_CYC=4 instance: 4-cycle OE window, ack 5 cycles after sampling
    b_req0 = 1; b_we0 = 0; b_addr0 = 20'h00040;
    for (int i = 0; i < 4; i++) begin
      step();
      check("a4_oe_low", 32'(b_Mem_OE), 0);
      check("a4_no_ack", 32'(b_ack0), 0);
    end
    check("a4_addr", 32'(b_Mem_ADDR), 32'h40);
    check("a4_wr_side", 32'({b_Mem_WE, b_Mem_drive}), 32'b10);
    step();
    check("a4_oe_high", 32'(b_Mem_OE), 1);
    check("a4_ack0", 32'(b_ack0), 1);
    check("a4_ack1", 32'(b_ack1), 0);
    check("a4_rdata", 32'(b_rdata), 32'hCAFE);
    check("a4_misc", 32'({b_Mem_CE, b_Mem_UB, b_Mem_LB, b_Data_to_SRAM}), 0);
    b_req0 = 0;
    step();
    check("a4_ack_gone", 32'(b_ack0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
